pipe_exu: RTL and testbench
===========================

Name: pipe_exu

Overview:
- Execute stage directly downstream of the decode stage. Consumes the decoded uop plus register-file read data once the ID/EX handshake completes.
- Computes ALU results, including an iterative multi-cycle MUL, and resolves branches and jumps.
- Presents the result to writeback through a valid/ready handshake.
- Drives flush/flush_pc back to the fetch stage on a taken control transfer.

Parameters:
- XLEN, 32, data/address width.
- MUL_CYCLES, XLEN, MUL iteration count (one multiplier bit per cycle).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- id_valid_i  in  1  decode holds a valid uop.
- ex_ready_o  out  1  execute can accept a uop this cycle.
- pc_i  in  XLEN  uop PC.
- rs1_rdata_i  in  XLEN  rs1 value.
- rs2_rdata_i  in  XLEN  rs2 value.
- imm_i  in  XLEN  sign-extended immediate.
- src2_imm_i  in  1  1: operand2=imm_i, 0: operand2=rs2_rdata_i.
- alu_op_i  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS2, 11 MUL(low XLEN); 12-15 produce result 0.
- is_branch_i  in  1  conditional branch.
- br_func_i  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; other codes are never taken.
- is_jal_i  in  1  JAL.
- is_jalr_i  in  1  JALR.
- rd_i  in  5  destination register.
- rd_wen_i  in  1  destination write enable.
- ex_valid_o  out  1  result valid toward writeback.
- wb_ready_i  in  1  writeback accepts.
- ex_result_o  out  XLEN  result.
- ex_rd_o  out  5  destination register.
- ex_rd_wen_o  out  1  destination write enable.
- flush_o  out  1  taken control transfer, redirect fetch.
- flush_pc_o  out  XLEN  redirect target.

Behaviour:
- Handshake rules:
  - Accept occurs when id_valid_i && ex_ready_o. All inputs are registered on accept.
  - ex_ready_o = (state==IDLE) || (state==VALID && wb_ready_i && !flush_o). This permits back-to-back issue for single-cycle ops.
  - Handoff occurs when ex_valid_o && wb_ready_i.
- States:
  - IDLE: empty, ex_valid_o=0.
    - Accept of a non-MUL uop -> VALID.
    - Accept of a MUL uop -> MUL_BUSY, with the iteration counter cleared.
  - MUL_BUSY: shift-add, one multiplier bit per cycle.
    - Partial product accumulates modulo 2^XLEN.
    - After MUL_CYCLES iterations -> VALID.
  - VALID: ex_valid_o=1.
    - Handoff with no new accept -> IDLE.
    - Handoff with a simultaneous accept -> VALID (non-MUL) or MUL_BUSY (MUL).
- Latency, for a uop accepted in cycle N:
  - Single-cycle op: ex_valid_o is high in cycle N+1.
  - MUL: ex_valid_o is high in cycle N+1+MUL_CYCLES.
- Backpressure: while ex_valid_o && !wb_ready_i, all ex_* outputs and flush_pc_o hold stable and no accept occurs.
- Arithmetic:
  - SLL/SRL/SRA use operand2[4:0].
  - SLT is signed, SLTU is unsigned.
  - ADD/SUB wrap modulo 2^XLEN.
  - Result bits above the low XLEN of MUL are discarded.
- Control transfer:
  - JAL/JALR: ex_result_o=pc+4 and taken=1.
    - JAL target = pc+imm.
    - JALR target = (rs1+imm) & ~1.
  - Branch: target = pc+imm. Taken per br_func_i comparing rs1 against rs2, always rs2 regardless of src2_imm_i. ex_result_o=0.
- Flush:
  - flush_o = taken && ex_valid_o && wb_ready_i, i.e. a one-cycle pulse exactly in the handoff cycle. flush_pc_o = target.
  - In a flush cycle, ex_ready_o=0. The younger uop offered upstream is never captured.
  - Not-taken branches and non-control uops never assert flush_o.
- Reset (rst_i low):
  - Asynchronously forces IDLE and clears the counter.
  - ex_valid_o=0, flush_o=0; ex_result_o, ex_rd_o, ex_rd_wen_o, flush_pc_o all 0.
  - Reset mid-MUL abandons the operation; no result is produced.
  - After reset release, ex_ready_o=1.

Test Plan:
- Reset, then ADD: rs1=5, rs2=7, alu_op=0, rd=3, rd_wen=1, accepted cycle N, wb_ready_i=1.
  - Required: ex_valid_o=1 only in N+1; ex_result_o=12; ex_rd_o=3; no flush.
  - A second uop presented in N+1 is accepted in N+1 (back-to-back).
- MUL: rs1=0xFFFFFFFF, rs2=3.
  - Required: ex_ready_o=0 during busy; ex_valid_o first high in cycle N+33; ex_result_o=0xFFFFFFFD.
- BNE taken: pc=0x80000010, imm=-16, rs1=1, rs2=2, wb_ready_i held 0 for 3 cycles, then 1.
  - While stalled: outputs stable, flush_o=0.
  - Handoff cycle: flush_o=1 for exactly one cycle, flush_pc_o=0x80000000, ex_ready_o=0.
- BEQ not taken with rs1=1, rs2=2 -> flush_o stays 0; handoff completes normally.
- JALR: pc=0x100, rs1=0x2001, imm=4 -> ex_result_o=0x104; flush_pc_o=0x2004; flush_o pulses once.
- Drop rst_i at the 10th MUL iteration.
  - Required: ex_valid_o=0 immediately; after release, ex_ready_o=1 and the next ADD completes with a correct result.

Source files
------------

// File: rtl/pipe_exu.sv
// Execute stage: single-cycle ALU, iterative shift-add MUL, branch/jump resolve.
// Result goes to writeback over valid/ready; taken transfers pulse flush on handoff.
module pipe_exu #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_rdata_i,
  input  logic [XLEN-1:0] rs2_rdata_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            src2_imm_i,
  input  logic [3:0]      alu_op_i,
  input  logic            is_branch_i,
  input  logic [2:0]      br_func_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic [4:0]      rd_i,
  input  logic            rd_wen_i,
  output logic            ex_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] ex_result_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_rd_wen_o,
  output logic            flush_o,
  output logic [XLEN-1:0] flush_pc_o
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] tgt_q;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [4:0]      rd_q;
  logic            rd_wen_q;
  logic            taken_q;

  logic [XLEN-1:0] op2;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] n_res;
  logic [XLEN-1:0] n_tgt;
  logic            n_taken;
  logic            br_take;
  logic            is_ctl;
  logic            is_mul;
  logic            accept;

  always_comb begin
    op2   = src2_imm_i ? imm_i : rs2_rdata_i;
    shamt = op2[4:0];
    case (alu_op_i)
      4'd0:    alu_res = rs1_rdata_i + op2;
      4'd1:    alu_res = rs1_rdata_i - op2;
      4'd2:    alu_res = rs1_rdata_i << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}},
                          $signed(rs1_rdata_i) < $signed(op2)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, rs1_rdata_i < op2};
      4'd5:    alu_res = rs1_rdata_i ^ op2;
      4'd6:    alu_res = rs1_rdata_i >> shamt;
      4'd7:    alu_res = $signed(rs1_rdata_i) >>> shamt;
      4'd8:    alu_res = rs1_rdata_i | op2;
      4'd9:    alu_res = rs1_rdata_i & op2;
      4'd10:   alu_res = op2;
      default: alu_res = '0;
    endcase
  end

  // Branch compare always uses rs2, never the immediate.
  always_comb begin
    case (br_func_i)
      3'b000:  br_take = rs1_rdata_i == rs2_rdata_i;
      3'b001:  br_take = rs1_rdata_i != rs2_rdata_i;
      3'b100:  br_take = $signed(rs1_rdata_i) < $signed(rs2_rdata_i);
      3'b101:  br_take = $signed(rs1_rdata_i) >= $signed(rs2_rdata_i);
      3'b110:  br_take = rs1_rdata_i < rs2_rdata_i;
      3'b111:  br_take = rs1_rdata_i >= rs2_rdata_i;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    is_ctl = is_jal_i | is_jalr_i;
    is_mul = !is_ctl && !is_branch_i && (alu_op_i == 4'd11);
    n_tgt  = pc_i + imm_i;
    if (is_ctl) begin
      n_res   = pc_i + XLEN'(4);
      n_taken = 1'b1;
      if (is_jalr_i)
        n_tgt = (rs1_rdata_i + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
    end else if (is_branch_i) begin
      n_res   = '0;
      n_taken = br_take;
    end else begin
      n_res   = alu_res;
      n_taken = 1'b0;
    end
  end

  assign ex_valid_o  = (state == VALID);
  assign flush_o     = taken_q && ex_valid_o && wb_ready_i;
  assign ex_ready_o  = (state == IDLE) ||
                       (ex_valid_o && wb_ready_i && !flush_o);
  assign accept      = id_valid_i && ex_ready_o;
  assign ex_result_o = res_q;
  assign ex_rd_o     = rd_q;
  assign ex_rd_wen_o = rd_wen_q;
  assign flush_pc_o  = tgt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      res_q    <= '0;
      tgt_q    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      taken_q  <= 1'b0;
    end else if (accept) begin
      rd_q     <= rd_i;
      rd_wen_q <= rd_wen_i;
      taken_q  <= n_taken;
      tgt_q    <= n_tgt;
      if (is_mul) begin
        state  <= BUSY;
        cnt    <= '0;
        res_q  <= '0;
        mcand  <= rs1_rdata_i;
        mplier <= op2;
      end else begin
        state  <= VALID;
        res_q  <= n_res;
      end
    end else begin
      case (state)
        BUSY: begin
          // One multiplier bit per cycle, accumulator wraps at XLEN.
          if (mplier[0])
            res_q <= res_q + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST)
            state <= VALID;
        end
        VALID: begin
          if (wb_ready_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_exu.sv
// Directed bench for pipe_exu: ALU ops, MUL latency, branches, jumps,
// writeback backpressure and reset in the middle of a MUL.
module tb_pipe_exu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        id_valid;
  logic        ex_ready;
  logic [31:0] pc;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm;
  logic        src2_imm;
  logic [3:0]  alu_op;
  logic        is_branch;
  logic [2:0]  br_func;
  logic        is_jal;
  logic        is_jalr;
  logic [4:0]  rd;
  logic        rd_wen;
  logic        ex_valid;
  logic        wb_ready;
  logic [31:0] ex_result;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen;
  logic        flush;
  logic [31:0] flush_pc;

  int vecs = 0;
  int errs = 0;

  pipe_exu #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_valid_i(id_valid), .ex_ready_o(ex_ready),
    .pc_i(pc), .rs1_rdata_i(rs1), .rs2_rdata_i(rs2),
    .imm_i(imm), .src2_imm_i(src2_imm), .alu_op_i(alu_op),
    .is_branch_i(is_branch), .br_func_i(br_func),
    .is_jal_i(is_jal), .is_jalr_i(is_jalr),
    .rd_i(rd), .rd_wen_i(rd_wen),
    .ex_valid_o(ex_valid), .wb_ready_i(wb_ready),
    .ex_result_o(ex_result), .ex_rd_o(ex_rd),
    .ex_rd_wen_o(ex_rd_wen),
    .flush_o(flush), .flush_pc_o(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_valid = 0; pc = 0; rs1 = 0; rs2 = 0; imm = 0;
    src2_imm = 0; alu_op = 0; is_branch = 0; br_func = 0;
    is_jal = 0; is_jalr = 0; rd = 0; rd_wen = 0;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] i,
                         input logic si, input logic [4:0] d);
    idle_in();
    id_valid = 1; alu_op = op; rs1 = a; rs2 = b; imm = i;
    src2_imm = si; rd = d; rd_wen = 1;
  endtask

  task automatic set_br(input logic [2:0] f, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] b);
    idle_in();
    id_valid = 1; is_branch = 1; br_func = f; pc = p; imm = i;
    rs1 = a; rs2 = b; src2_imm = 1;
  endtask

  task automatic test_reset();
    idle_in();
    wb_ready = 1;
    rst_i = 0;
    #3;
    vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", ex_valid); end
    vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL rst_flush: got %b want 0", flush); end
    vecs++; if ({ex_result, ex_rd, ex_rd_wen, flush_pc} !== 70'd0) begin
      errs++; $display("FAIL rst_outs: res %h rd %0d wen %b fpc %h want all 0", ex_result, ex_rd, ex_rd_wen, flush_pc);
    end
    step(); step();
    rst_i = 1;
    step();
    vecs++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", ex_ready); end
  endtask

  task automatic test_add_back_to_back();
    set_alu(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3);
    #1;
    vecs++; if (ex_ready !== 1'b1 || ex_valid !== 1'b0) begin
      errs++; $display("FAIL add_accept: ready %b valid %b want 1 0", ex_ready, ex_valid);
    end
    step();
    set_alu(4'd1, 32'd10, 32'd3, 32'd0, 1'b0, 5'd4);
    #1;
    vecs++; if (ex_valid !== 1'b1 || ex_result !== 32'd12) begin
      errs++; $display("FAIL add_result: valid %b res %0d want 1 12", ex_valid, ex_result);
    end
    vecs++; if (ex_rd !== 5'd3 || ex_rd_wen !== 1'b1 || flush !== 1'b0) begin
      errs++; $display("FAIL add_rd: rd %0d wen %b flush %b want 3 1 0", ex_rd, ex_rd_wen, flush);
    end
    vecs++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %b want 1", ex_ready); end
    step();
    idle_in();
    #1;
    vecs++; if (ex_valid !== 1'b1 || ex_result !== 32'd7 || ex_rd !== 5'd4) begin
      errs++; $display("FAIL b2b_result: valid %b res %0d rd %0d want 1 7 4", ex_valid, ex_result, ex_rd);
    end
    step();
    vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL add_drain: valid %b want 0", ex_valid); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  t_op  [12] = '{4'd2, 4'd7, 4'd6, 4'd3, 4'd4, 4'd5,
                                4'd8, 4'd9, 4'd10, 4'd1, 4'd0, 4'd13};
    logic [31:0] t_a   [12] = '{32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'hF0F0, 32'hF0, 32'hF0,
                                32'h0, 32'h0, 32'hFFFFFFFF, 32'h55};
    logic [31:0] t_b   [12] = '{32'h0, 32'h4, 32'h4, 32'h1, 32'h1, 32'hFF00,
                                32'h0F, 32'h3C, 32'h1234, 32'h1, 32'h2, 32'h66};
    logic [31:0] t_i   [12] = '{32'h24, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        t_si  [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_exp [12] = '{32'h10, 32'hF8000000, 32'h08000000, 32'h1,
                                32'h0, 32'h0FF0, 32'hFF, 32'h30, 32'h1234,
                                32'hFFFFFFFF, 32'h1, 32'h0};
    for (int k = 0; k < 12; k++) begin
      set_alu(t_op[k], t_a[k], t_b[k], t_i[k], t_si[k], 5'd9);
      step();
      idle_in();
      #1;
      vecs++; if (ex_valid !== 1'b1 || ex_result !== t_exp[k]) begin
        errs++; $display("FAIL alu_op%0d: valid %b res %h want 1 %h", t_op[k], ex_valid, ex_result, t_exp[k]);
      end
      step();
    end
  endtask

  task automatic test_mul();
    int bad = 0;
    set_alu(4'd11, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b0, 5'd5);
    #1;
    vecs++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL mul_accept: ready %b want 1", ex_ready); end
    step();
    idle_in();
    for (int k = 1; k <= 32; k++) begin
      #1;
      if (ex_valid !== 1'b0 || ex_ready !== 1'b0) bad++;
      step();
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL mul_busy: %0d busy cycles with valid/ready high, want 0", bad); end
    vecs++; if (ex_valid !== 1'b1 || ex_result !== 32'hFFFFFFFD || ex_rd !== 5'd5) begin
      errs++; $display("FAIL mul_result: valid %b res %h rd %0d want 1 fffffffd 5", ex_valid, ex_result, ex_rd);
    end
    step();
    vecs++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL mul_drain: valid %b want 0", ex_valid); end
  endtask

  task automatic test_bne_stall();
    wb_ready = 0;
    set_br(3'b001, 32'h80000010, 32'hFFFFFFF0, 32'd1, 32'd2);
    #1;
    vecs++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL bne_accept: ready %b want 1", ex_ready); end
    step();
    set_alu(4'd0, 32'd9, 32'd9, 32'd0, 1'b0, 5'd7);
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++; if (ex_valid !== 1'b1 || flush !== 1'b0 || ex_ready !== 1'b0 ||
                  ex_result !== 32'd0 || flush_pc !== 32'h80000000 || ex_rd !== 5'd0) begin
        errs++; $display("FAIL bne_stall%0d: valid %b flush %b ready %b res %h fpc %h rd %0d", k, ex_valid, flush, ex_ready, ex_result, flush_pc, ex_rd);
      end
      step();
    end
    wb_ready = 1;
    #1;
    vecs++; if (flush !== 1'b1 || flush_pc !== 32'h80000000 || ex_ready !== 1'b0 || ex_valid !== 1'b1) begin
      errs++; $display("FAIL bne_flush: flush %b fpc %h ready %b valid %b want 1 80000000 0 1", flush, flush_pc, ex_ready, ex_valid);
    end
    step();
    idle_in();
    #1;
    vecs++; if (flush !== 1'b0 || ex_valid !== 1'b0) begin
      errs++; $display("FAIL bne_after: flush %b valid %b want 0 0 (younger uop captured?)", flush, ex_valid);
    end
    step();
  endtask

  task automatic test_branches();
    logic [2:0]  t_f [5] = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [31:0] t_a [5] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_b [5] = '{32'd2, 32'd1, 32'd1, 32'd1, 32'd1};
    logic        t_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      // imm == rs1 so a branch wrongly comparing against imm would flip BEQ
      set_br(t_f[k], 32'h200, 32'd1, t_a[k], t_b[k]);
      step();
      idle_in();
      #1;
      vecs++; if (ex_valid !== 1'b1 || flush !== t_t[k] || ex_result !== 32'd0) begin
        errs++; $display("FAIL br_f%0d: valid %b flush %b res %h want 1 %b 0", t_f[k], ex_valid, flush, ex_result, t_t[k]);
      end
      step();
    end
  endtask

  task automatic test_jumps();
    idle_in();
    id_valid = 1; is_jalr = 1; pc = 32'h100; rs1 = 32'h2001; imm = 32'd4;
    src2_imm = 1; rd = 5'd1; rd_wen = 1;
    step();
    idle_in();
    #1;
    vecs++; if (ex_result !== 32'h104 || flush_pc !== 32'h2004 || flush !== 1'b1) begin
      errs++; $display("FAIL jalr: res %h fpc %h flush %b want 104 2004 1", ex_result, flush_pc, flush);
    end
    step();
    vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL jalr_pulse: flush %b want 0", flush); end
    idle_in();
    id_valid = 1; is_jal = 1; pc = 32'h1000; imm = 32'h20; rd = 5'd1; rd_wen = 1;
    step();
    idle_in();
    #1;
    vecs++; if (ex_result !== 32'h1004 || flush_pc !== 32'h1020 || flush !== 1'b1) begin
      errs++; $display("FAIL jal: res %h fpc %h flush %b want 1004 1020 1", ex_result, flush_pc, flush);
    end
    step();
  endtask

  task automatic test_mul_reset();
    int bad = 0;
    set_alu(4'd11, 32'd7, 32'd6, 32'd0, 1'b0, 5'd6);
    step();
    idle_in();
    for (int k = 1; k < 10; k++) step();
    rst_i = 0;
    #1;
    vecs++; if (ex_valid !== 1'b0 || ex_result !== 32'd0 || flush !== 1'b0) begin
      errs++; $display("FAIL mulrst_outs: valid %b res %h flush %b want 0 0 0", ex_valid, ex_result, flush);
    end
    step();
    rst_i = 1;
    #1;
    vecs++; if (ex_ready !== 1'b1 || ex_valid !== 1'b0) begin
      errs++; $display("FAIL mulrst_ready: ready %b valid %b want 1 0", ex_ready, ex_valid);
    end
    set_alu(4'd0, 32'd20, 32'd22, 32'd0, 1'b0, 5'd2);
    step();
    idle_in();
    #1;
    vecs++; if (ex_valid !== 1'b1 || ex_result !== 32'd42 || ex_rd !== 5'd2) begin
      errs++; $display("FAIL mulrst_add: valid %b res %0d rd %0d want 1 42 2", ex_valid, ex_result, ex_rd);
    end
    step();
    for (int k = 0; k < 40; k++) begin
      if (ex_valid !== 1'b0) bad++;
      step();
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL mulrst_ghost: %0d cycles valid after abandon, want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_add_back_to_back();
    test_alu_ops();
    test_mul();
    test_bne_stall();
    test_branches();
    test_jumps();
    test_mul_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
